// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bit_add_cell.sv
// One-bit full adder built from two half-add stages with an OR merging the carries.
module bit_add_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1;
  logic hc1;
  logic hc2;

  assign hs1 = x ^ y;
  assign hc1 = x & y;
  assign s   = hs1 ^ ci;
  assign hc2 = hs1 & ci;
  assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock LSB first,
// through a single bit_add_cell sequenced by an IDLE/RUN/DONE controller.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  state_e           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             accept_c;
  logic             step_c;
  logic             last_c;
  logic             bit_s;
  logic             bit_co;

  bit_add_cell u_cell (
    .x  (a_q[cnt_q]),
    .y  (b_q[cnt_q]),
    .ci (carry_q),
    .s  (bit_s),
    .co (bit_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    accept_c  = 1'b0;
    step_c    = 1'b0;
    last_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept_c  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        step_c = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          last_c    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept_c  = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ready <= (state_nxt != ST_RUN);
      busy  <= (state_nxt == ST_RUN);
      done  <= (state_nxt == ST_DONE);
    end
  end

  // Operand capture and the serial datapath; the counter parks at 0 after the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept_c) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (step_c) begin
      sum[cnt_q] <= bit_s;
      carry_q    <= bit_co;
      if (last_c) begin
        cout  <= bit_co;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of the bit-serial adder at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int failures;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after an accepted start; returns cycles waited and busy cycles seen.
  task automatic wait_done(output int n, output int busy_cnt);
    n = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic [W-1:0] es, input logic ec);
    int n;
    int bc;
    a = ai; b = bi; cin = ci; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_ready_lo"}, 32'(ready), 32'd0);
    wait_done(n, bc);
    check({tag, "_lat"}, 32'(n), 32'(W));
    check({tag, "_busycnt"}, 32'(bc), 32'(W));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    tick();
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'({cout, sum}), 32'({ec, es}));
  endtask

  initial begin
    int n;
    int bc;
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   exp;

    checks = 0;
    failures = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

    // Start pulse and operand changes mid-run must not disturb 0x12+0x34.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    wait_done(n, bc);
    check("ign_lat", 32'(n), 32'(W - 4));
    check("ign_sum", 32'(sum), 32'h46);
    check("ign_cout", 32'(cout), 32'd0);
    tick();
    check("ign_idle", 32'({ready, busy, done}), 32'b100);

    // Back-to-back: start held through RUN and DONE; the second op issues at done.
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    tick();
    a = 8'h80; b = 8'h80;
    wait_done(n, bc);
    check("b2b_lat1", 32'(n), 32'(W));
    check("b2b_sum1", 32'({cout, sum}), 32'h003);
    tick();
    start = 1'b0;
    check("b2b_rerun", 32'({ready, busy, done}), 32'b010);
    wait_done(n, bc);
    check("b2b_period", 32'(n + 1), 32'(W + 1));
    check("b2b_sum2", 32'({cout, sum}), 32'h100);
    tick();

    // Asynchronous abort in the fourth RUN cycle.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("abort_pre", 32'(sum), 32'h06);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_flags", 32'({ready, busy, done}), 32'b100);
    check("abort_res", 32'({cout, sum}), 32'h000);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen++;
    end
    check("abort_nodone", 32'(seen), 32'd0);
    run_op("post_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      exp = (W + 1)'(ra) + (W + 1)'(rb) + (W + 1)'(rc);
      a = ra; b = rb; cin = rc; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(n, bc);
      check("rnd", 32'({done, cout, sum}), 32'({1'b1, exp}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
